// File: rtl/nor_logic_unit_pipe_pkg.sv
// Shared definitions for the bitwise logic unit: op-code encoding, op width
// and the output-buffer occupancy states.
package nor_logic_unit_pipe_pkg;

  localparam int unsigned OP_W = 3;

  // Bitwise operation select
  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_NOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  // Output buffer occupancy (0, 1 or 2 entries)
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/nor_logic_unit_pipe_logic_slice.sv
// logic_slice: purely combinational WIDTH-bit bitwise op evaluator.
// Ports:
//   a, b   : operands (b unused by NOT a / PASS a)
//   op     : operation select (op_e encoding)
//   res_c  : combinational result
module logic_slice
  import nor_logic_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] res_c
);

  // Op decode
  always_comb begin
    res_c = '0;
    case (op)
      OP_AND:   res_c = a & b;
      OP_OR:    res_c = a | b;
      OP_NOR:   res_c = ~(a | b);
      OP_NAND:  res_c = ~(a & b);
      OP_XOR:   res_c = a ^ b;
      OP_XNOR:  res_c = ~(a ^ b);
      OP_NOTA:  res_c = ~a;
      OP_PASSA: res_c = a;
      default:  res_c = '0;
    endcase
  end

endmodule

// File: rtl/nor_logic_unit_pipe.sv
// nor_logic_unit_pipe: registered WIDTH-bit bitwise logic unit with valid/ready
// handshakes, a 2-entry output FIFO, an all-zero result flag and a counter of
// completed (popped) operations.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : operand beat handshake (in_ready registered)
//   in_a, in_b, in_op             : operands and op select
//   out_valid/out_ready           : result handshake (out_valid registered)
//   out_res, out_zero             : head result and its reduction-NOR flag
//   op_count                      : pops since reset, wrapping
module nor_logic_unit_pipe
  import nor_logic_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_res_q, head_res_d;
  logic             head_zero_q, head_zero_d;
  logic [WIDTH-1:0] tail_res_q, tail_res_d;
  logic             tail_zero_q, tail_zero_d;
  logic [WIDTH-1:0] slice_res_c;
  logic             slice_zero_c;
  logic             push_c;
  logic             pop_c;

  logic_slice #(.WIDTH(WIDTH)) u_slice (
    .a     (in_a),
    .b     (in_b),
    .op    (in_op),
    .res_c (slice_res_c)
  );

  assign slice_zero_c = ~|slice_res_c;

  // Handshakes depend only on registered state, so no out_ready->in_ready path
  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  assign out_res  = head_res_q;
  assign out_zero = head_zero_q;

  // Buffer next-state: head is the FIFO front, tail the second entry
  always_comb begin
    occ_d       = occ_q;
    head_res_d  = head_res_q;
    head_zero_d = head_zero_q;
    tail_res_d  = tail_res_q;
    tail_zero_d = tail_zero_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push_c) begin
          head_res_d  = slice_res_c;
          head_zero_d = slice_zero_c;
          occ_d       = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push_c) begin
          if (pop_c) begin
            // Head leaves as the new beat arrives: new beat becomes head
            head_res_d  = slice_res_c;
            head_zero_d = slice_zero_c;
          end else begin
            tail_res_d  = slice_res_c;
            tail_zero_d = slice_zero_c;
            occ_d       = OCC_FULL;
          end
        end else if (pop_c) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop_c) begin
          head_res_d  = tail_res_q;
          head_zero_d = tail_zero_q;
          occ_d       = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // State, handshake flags and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= OCC_EMPTY;
      head_res_q  <= '0;
      head_zero_q <= 1'b1;
      tail_res_q  <= '0;
      tail_zero_q <= 1'b1;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      op_count    <= '0;
    end else begin
      occ_q       <= occ_d;
      head_res_q  <= head_res_d;
      head_zero_q <= head_zero_d;
      tail_res_q  <= tail_res_d;
      tail_zero_q <= tail_zero_d;
      in_ready    <= (occ_d != OCC_FULL);
      out_valid   <= (occ_d != OCC_EMPTY);
      if (pop_c) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nor_logic_unit_pipe.sv
// Testbench for nor_logic_unit_pipe: directed vectors with hand-computed
// results; expected beats are queued on acceptance and a negedge monitor pops
// and compares whenever the DUT hands over a result.
module tb_nor_logic_unit_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
  } exp_t;

  exp_t             sb[$];
  exp_t             drv_exp;
  exp_t             mon_e;
  logic [CNT_W-1:0] model_cnt = '0;
  int               n_checks = 0;
  int               n_errors = 0;

  nor_logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: pop on each handover, push on each accepted beat
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_cnt = '0;
    end else begin
      chk("op_count", 32'(op_count), 32'(model_cnt));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("out_res", 32'(out_res), 32'(mon_e.res));
          chk("out_zero", 32'(out_zero), 32'(mon_e.zero));
          model_cnt = model_cnt + 4'd1;
        end
      end
      if (in_valid && in_ready) sb.push_back(drv_exp);
    end
  end

  // Present a beat and hold it until accepted; returns at posedge+1 after acceptance
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, output int waits);
    in_valid     = 1'b1;
    in_op        = op;
    in_a         = a;
    in_b         = b;
    drv_exp.res  = r;
    drv_exp.zero = (r == 8'h00);
    waits = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
    end
    if (waits >= 50) chk("accept_timeout", 32'(waits), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 30; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_queue", 32'(sb.size()), 32'(0));
    chk("drain_valid", 32'(out_valid), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] tbl [8];
    int w;
    tbl[0] = 8'h24; tbl[1] = 8'hBD; tbl[2] = 8'h42; tbl[3] = 8'hDB;
    tbl[4] = 8'h99; tbl[5] = 8'h66; tbl[6] = 8'h5A; tbl[7] = 8'hA5;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b0; drv_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_res", 32'(out_res), 32'(0));
    chk("rst_out_zero", 32'(out_zero), 32'(1));
    chk("rst_op_count", 32'(op_count), 32'(0));

    // NOR with 1-cycle latency
    out_ready = 1'b1;
    send(3'b010, 8'hF0, 8'h0C, 8'h03, w);
    in_valid = 1'b0;
    chk("nor_lat_valid", 32'(out_valid), 32'(1));
    chk("nor_lat_res", 32'(out_res), 32'h03);
    chk("nor_lat_zero", 32'(out_zero), 32'(0));
    @(posedge clk);
    #1;
    chk("nor_op_count", 32'(op_count), 32'(1));

    // All eight ops back to back
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 8'hA5, 8'h3C, tbl[i], w);
      chk("no_bubble_wait", 32'(w), 32'(0));
      chk("no_bubble_res", 32'(out_res), 32'(tbl[i]));
    end
    in_valid = 1'b0;
    drain();

    // Stall: two beats fill the buffer, third is held off
    out_ready = 1'b0;
    send(3'b100, 8'h12, 8'h34, 8'h26, w);
    send(3'b001, 8'h40, 8'h02, 8'h42, w);
    in_valid = 1'b1; in_op = 3'b000; in_a = 8'hFF; in_b = 8'h81;
    drv_exp.res = 8'h81; drv_exp.zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_head", 32'(out_res), 32'h26);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'b000, 8'hFF, 8'h81, 8'h81, w);
    in_valid = 1'b0;
    drain();

    // Zero flag
    send(3'b000, 8'h0F, 8'hF0, 8'h00, w);
    in_valid = 1'b0;
    chk("zero_res", 32'(out_res), 32'(0));
    chk("zero_flag", 32'(out_zero), 32'(1));
    drain();

    // Counter wrap: 17 pops from reset
    do_reset();
    for (int i = 0; i < 17; i++) send(3'b111, 8'(i + 1), 8'h00, 8'(i + 1), w);
    in_valid = 1'b0;
    drain();
    chk("wrap_op_count", 32'(op_count), 32'(1));

    // Reset with buffer full and a beat presented alongside rst
    out_ready = 1'b0;
    send(3'b101, 8'h0F, 8'h0F, 8'hFF, w);
    send(3'b110, 8'h0F, 8'h00, 8'hF0, w);
    chk("mid_full", 32'(in_ready), 32'(0));
    in_valid = 1'b1; in_op = 3'b111; in_a = 8'h77;
    drv_exp.res = 8'h77; drv_exp.zero = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 32'(0));
    chk("mid_in_ready", 32'(in_ready), 32'(1));
    chk("mid_op_count", 32'(op_count), 32'(0));
    chk("mid_out_res", 32'(out_res), 32'(0));
    chk("mid_out_zero", 32'(out_zero), 32'(1));
    out_ready = 1'b1;
    send(3'b001, 8'h12, 8'h21, 8'h33, w);
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'(1));
    chk("post_rst_res", 32'(out_res), 32'h33);
    drain();

    chk("final_queue", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
